tff_bank_arbiter: RTL

TFF_BANK_ARBITER -- requirements
Module: tff_bank_arbiter

---
 rtl/tff_ctrl_pkg.sv | 19 +
 rtl/tff_cell.sv | 30 +++
 rtl/tff_bank_arbiter.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/tff_ctrl_pkg.sv
// Shared constants for the T-flip-flop bank arbiter: opcodes, FSM states, defaults.
package tff_ctrl_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned DEFAULT_NREQ  = 4;

    localparam logic [1:0] OP_HOLD   = 2'b00;
    localparam logic [1:0] OP_LOAD   = 2'b01;
    localparam logic [1:0] OP_TOGGLE = 2'b10;
    localparam logic [1:0] OP_CLEAR  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        EXEC  = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/tff_cell.sv
// Single T flip-flop with complementary output and async active-low reset.
module tff_cell (
    input  logic clk,
    input  logic rst,
    input  logic t,
    output logic q,
    output logic qb
);

    logic q_q;
    logic q_d;

    // Toggle when t is high, otherwise hold.
    always_comb begin
        q_d = q_q ^ t;
    end

    // State flop, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q  = q_q;
    assign qb = ~q_q;

endmodule

// File: rtl/tff_bank_arbiter.sv
// Round-robin arbiter granting NREQ requesters access to a WIDTH-bit T-flip-flop bank.
// Each transaction walks IDLE -> GRANT -> EXEC -> DONE, one state per cycle.
module tff_bank_arbiter
    import tff_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned NREQ  = DEFAULT_NREQ
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [2*NREQ-1:0]       op,
    input  logic [WIDTH*NREQ-1:0]   wdata,
    output logic [NREQ-1:0]         gnt,
    output logic                    ack,
    output logic                    busy,
    output logic [WIDTH-1:0]        q,
    output logic [WIDTH-1:0]        qb
);

    localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t             state_q, state_d;
    logic [NREQ-1:0]    gnt_q, gnt_d;
    logic               ack_q, ack_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   winner_q, winner_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   data_q, data_d;

    logic [1:0]         op_arr   [NREQ];
    logic [WIDTH-1:0]   data_arr [NREQ];
    logic [WIDTH-1:0]   t_vec;
    logic [PTR_W-1:0]   idx;
    logic               found;

    // Unpack the per-requester opcode and operand fields.
    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            op_arr[i]   = op[2*i +: 2];
            data_arr[i] = wdata[WIDTH*i +: WIDTH];
        end
    end

    // Next-state, round-robin selection, operand latch and grant/ack generation.
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        ack_d    = 1'b0;
        ptr_d    = ptr_q;
        winner_d = winner_q;
        op_d     = op_q;
        data_d   = data_q;
        found    = 1'b0;
        idx      = '0;
        unique case (state_q)
            IDLE: begin
                gnt_d = '0;
                // Scan from ptr upward (wrapping); first pending request wins.
                for (int unsigned i = 0; i < NREQ; i++) begin
                    idx = PTR_W'((32'(ptr_q) + i) % NREQ);
                    if (!found && req[idx]) begin
                        found    = 1'b1;
                        winner_d = idx;
                        gnt_d[idx] = 1'b1;
                    end
                end
                if (found) begin
                    state_d = GRANT;
                end
            end
            GRANT: begin
                op_d    = op_arr[winner_q];
                data_d  = data_arr[winner_q];
                state_d = EXEC;
            end
            EXEC: begin
                ack_d   = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                gnt_d   = '0;
                ptr_d   = (winner_q == PTR_W'(NREQ - 1)) ? '0 : winner_q + PTR_W'(1);
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Toggle vector: nonzero only during EXEC so the bank changes on that edge alone.
    always_comb begin
        t_vec = '0;
        if (state_q == EXEC) begin
            case (op_q)
                OP_HOLD:   t_vec = '0;
                OP_LOAD:   t_vec = data_q ^ q;
                OP_TOGGLE: t_vec = data_q;
                OP_CLEAR:  t_vec = q;
                default:   t_vec = '0;
            endcase
        end
    end

    // Control registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            ack_q    <= 1'b0;
            ptr_q    <= '0;
            winner_q <= '0;
            op_q     <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            ack_q    <= ack_d;
            ptr_q    <= ptr_d;
            winner_q <= winner_d;
            op_q     <= op_d;
            data_q   <= data_d;
        end
    end

    for (genvar b = 0; b < WIDTH; b++) begin : g_bank
        tff_cell u_cell (
            .clk (clk),
            .rst (rst),
            .t   (t_vec[b]),
            .q   (q[b]),
            .qb  (qb[b])
        );
    end

    assign gnt  = gnt_q;
    assign ack  = ack_q;
    assign busy = (state_q != IDLE);

endmodule
